// File: rtl/chunk_serial_adder.sv
// -----------------------------------------------------------------------------
// chunk_serial_adder
//
// Multi-cycle adder / subtractor / accumulator. A WIDTH-bit operation is split
// into N = WIDTH/CHUNK slices; one CHUNK-bit slice is added per RUN cycle and
// the carry is registered between slices, so the combinational carry chain is
// only CHUNK bits long. WIDTH must be an integer multiple of CHUNK.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request; sampled only in IDLE or DONE
//   mode   in   2      00 add, 01 sub (a-b), 10 acc (sum+b), 11 clear
//   a      in   WIDTH  operand A (add/sub only)
//   b      in   WIDTH  operand B (add/sub/acc)
//   cin    in   1      carry-in for add/acc
//   busy   out  1      high while an operation is running
//   done   out  1      one-cycle pulse after the result registers update
//   sum    out  WIDTH  registered result, held until the next completion
//   cout   out  1      carry out of the MSB (sub: 1 = no borrow)
//   ovf    out  1      signed overflow
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module chunk_serial_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int N     = WIDTH / CHUNK;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [1:0] MODE_ADD = 2'b00;
   localparam logic [1:0] MODE_SUB = 2'b01;
   localparam logic [1:0] MODE_ACC = 2'b10;
   localparam logic [1:0] MODE_CLR = 2'b11;

   logic [1:0]       state;
   logic [IDX_W-1:0] idx;
   // Operand registers are shifted right one chunk per RUN cycle, so the
   // slice being added is always the low CHUNK bits.
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   // Partial result; each new slice enters at the top and the register shifts
   // right, so after N cycles the slices sit in their final positions.
   logic [WIDTH-1:0] work;
   logic             carry;

   logic [CHUNK:0]   chunk_res;
   logic [WIDTH-1:0] work_next;
   logic             last_chunk;
   logic             msb_carry_in;

   // NOTE: every signal driven here gets a value on every path (no
   // conditionals at all), so no latch can be inferred.
   always_comb begin
      chunk_res  = {1'b0, op_a[CHUNK-1:0]} + {1'b0, op_b[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, carry};
      work_next  = (work >> CHUNK) | (WIDTH'(chunk_res[CHUNK-1:0]) << (WIDTH - CHUNK));
      last_chunk = (idx == IDX_W'(N - 1));
      // In the final slice the operand MSBs are op_a/op_b[CHUNK-1]; the carry
      // into a full-adder bit equals a ^ b ^ s of that bit.
      msb_carry_in = op_a[CHUNK-1] ^ op_b[CHUNK-1] ^ chunk_res[CHUNK-1];
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the datapath registers are plain flops (no memory array),
         // so they are reset along with the control state.
         state <= S_IDLE;
         idx   <= '0;
         op_a  <= '0;
         op_b  <= '0;
         work  <= '0;
         carry <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  if (mode == MODE_CLR) begin
                     sum   <= '0;
                     cout  <= 1'b0;
                     ovf   <= 1'b0;
                     state <= S_DONE;
                  end else begin
                     // Acc takes the result currently on the outputs, which
                     // is already final when accepted straight from DONE.
                     op_a  <= (mode == MODE_ACC) ? sum : a;
                     op_b  <= (mode == MODE_SUB) ? ~b : b;
                     carry <= (mode == MODE_SUB) ? 1'b1 : cin;
                     idx   <= '0;
                     state <= S_RUN;
                  end
               end else begin
                  state <= S_IDLE;
               end
            end

            S_RUN: begin
               op_a  <= op_a >> CHUNK;
               op_b  <= op_b >> CHUNK;
               work  <= work_next;
               carry <= chunk_res[CHUNK];
               if (last_chunk) begin
                  sum   <= work_next;
                  cout  <= chunk_res[CHUNK];
                  ovf   <= msb_carry_in ^ chunk_res[CHUNK];
                  idx   <= '0;
                  state <= S_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy = (state == S_RUN);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_chunk_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_chunk_serial_adder
//
// Drives a 16/4 instance and an 8/8 instance of chunk_serial_adder. Expected
// results come from an arithmetic reference model and are queued at issue
// time; per-instance monitors pop and compare on every done pulse.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_chunk_serial_adder;

   localparam logic [1:0] M_ADD = 2'b00;
   localparam logic [1:0] M_SUB = 2'b01;
   localparam logic [1:0] M_ACC = 2'b10;
   localparam logic [1:0] M_CLR = 2'b11;

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // 16-bit, 4-bit chunk instance
   logic        start16, cin16, busy16, done16, cout16, ovf16;
   logic [1:0]  mode16;
   logic [15:0] a16, b16, sum16;
   // 8-bit, single-chunk instance
   logic        start8, cin8, busy8, done8, cout8, ovf8;
   logic [1:0]  mode8;
   logic [7:0]  a8, b8, sum8;

   chunk_serial_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode16), .a(a16), .b(b16),
      .cin(cin16), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16));

   chunk_serial_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8),
      .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

   int checks = 0;
   int errors = 0;
   exp_t q16[$];
   exp_t q8[$];
   logic [15:0] model_sum16;
   logic [15:0] model_sum8;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed views.
   function automatic exp_t ref_op(input int w, input logic [1:0] m, input logic [15:0] x,
                                   input logic [15:0] y, input logic ci, input logic [15:0] acc);
      exp_t   r;
      longint lim, ux, uy, sx, sy, total, st;
      r.sum = '0; r.cout = 1'b0; r.ovf = 1'b0;
      if (m == M_CLR) return r;
      lim = longint'(1) << w;
      ux  = (m == M_ACC) ? longint'(acc) : longint'(x);
      uy  = longint'(y);
      sx  = (ux >= lim / 2) ? ux - lim : ux;
      sy  = (uy >= lim / 2) ? uy - lim : uy;
      if (m == M_SUB) begin
         total  = ux - uy;
         r.cout = (ux >= uy);
         st     = sx - sy;
         if (total < 0) total = total + lim;
      end else begin
         total  = ux + uy + longint'(ci);
         r.cout = (total >= lim);
         st     = sx + sy + longint'(ci);
         total  = total % lim;
      end
      r.ovf = (st > lim / 2 - 1) || (st < -(lim / 2));
      r.sum = 16'(total);
      return r;
   endfunction

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (rst_n && done16) begin
         if (q16.size() == 0) check("extra_done16", 32'(done16), 32'd0);
         else begin
            exp_t e;
            e = q16.pop_front();
            check("sb16_sum", 32'(sum16), 32'(e.sum));
            check("sb16_cout", 32'(cout16), 32'(e.cout));
            check("sb16_ovf", 32'(ovf16), 32'(e.ovf));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && done8) begin
         if (q8.size() == 0) check("extra_done8", 32'(done8), 32'd0);
         else begin
            exp_t e;
            e = q8.pop_front();
            check("sb8_sum", 32'(sum8), 32'(e.sum[7:0]));
            check("sb8_cout", 32'(cout8), 32'(e.cout));
            check("sb8_ovf", 32'(ovf8), 32'(e.ovf));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push16(input logic [1:0] m, input logic [15:0] x, input logic [15:0] y, input logic c);
      exp_t e;
      e = ref_op(16, m, x, y, c, model_sum16);
      q16.push_back(e);
      model_sum16 = e.sum;
   endtask

   // Called at a negedge while the DUT is not running.
   task automatic issue16(input logic [1:0] m, input logic [15:0] x, input logic [15:0] y,
                          input logic c, input bit push);
      start16 = 1'b1; mode16 = m; a16 = x; b16 = y; cin16 = c;
      if (push) push16(m, x, y, c);
      @(posedge clk);
      #1 start16 = 1'b0;
   endtask

   task automatic issue8(input logic [1:0] m, input logic [7:0] x, input logic [7:0] y, input logic c);
      exp_t e;
      start8 = 1'b1; mode8 = m; a8 = x; b8 = y; cin8 = c;
      e = ref_op(8, m, {8'h00, x}, {8'h00, y}, c, model_sum8);
      q8.push_back(e);
      model_sum8 = e.sum;
      @(posedge clk);
      #1 start8 = 1'b0;
   endtask

   // Returns at the negedge where done is seen; counts busy cycles on the
   // way and scrambles the inputs, which must not affect the running op.
   task automatic wait_done16(output int cyc);
      bit seen = 0;
      cyc = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done16) begin seen = 1; break; end
         if (busy16) begin
            cyc++;
            a16 = 16'($urandom); b16 = 16'($urandom);
            mode16 = 2'($urandom); cin16 = 1'($urandom);
         end
      end
      if (!seen) check("done16_timeout", 32'(done16), 32'd1);
   endtask

   task automatic wait_done8(output int cyc);
      bit seen = 0;
      cyc = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done8) begin seen = 1; break; end
         if (busy8) begin
            cyc++;
            a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 2'($urandom);
         end
      end
      if (!seen) check("done8_timeout", 32'(done8), 32'd1);
   endtask

   task automatic dir16(input string nm, input logic [1:0] m, input logic [15:0] x,
                        input logic [15:0] y, input logic c, input logic [15:0] es,
                        input logic ec, input logic eo, input int ecyc);
      int cyc;
      issue16(m, x, y, c, 1'b1);
      wait_done16(cyc);
      check({nm, "_sum"}, 32'(sum16), 32'(es));
      check({nm, "_cout"}, 32'(cout16), 32'(ec));
      check({nm, "_ovf"}, 32'(ovf16), 32'(eo));
      check({nm, "_busy_cycles"}, 32'(cyc), 32'(ecyc));
      @(negedge clk);
      check({nm, "_done_pulse"}, 32'(done16), 32'd0);
   endtask

   function automatic logic [15:0] pick16();
      case ($urandom_range(0, 7))
         0: return 16'hFFFF;
         1: return 16'h8000;
         2: return 16'h7FFF;
         3: return 16'h0000;
         default: return 16'($urandom);
      endcase
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      int cyc, t, last_t, dones, extra;
      rst_n = 1'b0;
      start16 = 0; mode16 = 0; a16 = 0; b16 = 0; cin16 = 0;
      start8 = 0; mode8 = 0; a8 = 0; b8 = 0; cin8 = 0;
      model_sum16 = '0; model_sum8 = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(busy16), 32'd0);
      check("reset_done", 32'(done16), 32'd0);
      check("reset_sum", 32'(sum16), 32'd0);
      check("reset_cout_ovf", {30'd0, cout16, ovf16}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1-3: directed add/sub corners
      dir16("t1_add", M_ADD, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 4);
      dir16("t2_wrap", M_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4);
      dir16("t2_ovf", M_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 4);
      dir16("t3_sub_neg", M_SUB, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, 4);
      dir16("t3_sub_ovf", M_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 4);

      // 4: clear, then three back-to-back accumulates with start held high
      issue16(M_CLR, 16'h0000, 16'h0000, 1'b0, 1'b1);
      wait_done16(cyc);
      check("t4_clear_sum", 32'(sum16), 32'd0);
      start16 = 1'b1; mode16 = M_ACC; b16 = 16'h0003; cin16 = 1'b0; a16 = 16'hABCD;
      repeat (3) push16(M_ACC, 16'hABCD, 16'h0003, 1'b0);
      t = 0; last_t = 0; dones = 0;
      for (int i = 0; i < 60 && dones < 3; i++) begin
         @(negedge clk);
         t++;
         if (done16) begin
            dones++;
            check("t4_acc_sum", 32'(sum16), 32'(3 * dones));
            if (dones > 1) check("t4_spacing", 32'(t - last_t), 32'd5);
            last_t = t;
            if (dones == 3) start16 = 1'b0;
         end
      end
      check("t4_three_dones", 32'(dones), 32'd3);
      @(negedge clk);
      check("t4_idle_after", 32'(done16 | busy16), 32'd0);

      // 5a: start pulsed mid-RUN is ignored
      issue16(M_ADD, 16'h1111, 16'h2222, 1'b0, 1'b1);
      @(negedge clk);
      start16 = 1'b1; mode16 = M_SUB; a16 = 16'hFFFF; b16 = 16'h0001;
      @(posedge clk);
      #1 start16 = 1'b0;
      wait_done16(cyc);
      check("t5_first_result", 32'(sum16), 32'h3333);
      extra = 0;
      repeat (8) begin @(negedge clk); if (done16) extra++; end
      check("t5_no_second_op", 32'(extra), 32'd0);

      // 5b: reset during RUN cycle 2 aborts with no done
      issue16(M_ADD, 16'h00FF, 16'h0001, 1'b0, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_outputs", {busy16, done16, cout16, ovf16, 12'd0, sum16}, 32'd0);
      model_sum16 = '0; model_sum8 = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      extra = 0;
      repeat (10) begin @(negedge clk); if (done16 || busy16) extra++; end
      check("t5_idle_after_rst", 32'(extra), 32'd0);

      // 6: single-chunk instance
      issue8(M_ADD, 8'hF0, 8'h10, 1'b0);
      wait_done8(cyc);
      check("t6_busy_cycles", 32'(cyc), 32'd1);
      check("t6_result", {23'd0, sum8, cout8, ovf8}, {23'd0, 8'h00, 1'b1, 1'b0});
      @(negedge clk);

      // Random operations, with random idle gaps (gap 0 = back-to-back)
      for (int n = 0; n < 1000; n++) begin
         logic [1:0] m;
         m = 2'($urandom_range(0, 3));
         if (m == M_CLR && $urandom_range(0, 3) != 0) m = M_ACC;
         issue16(m, pick16(), pick16(), 1'($urandom), 1'b1);
         wait_done16(cyc);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      for (int n = 0; n < 200; n++) begin
         logic [1:0] m;
         m = 2'($urandom_range(0, 3));
         if (m == M_CLR && $urandom_range(0, 3) != 0) m = M_SUB;
         issue8(m, 8'($urandom), 8'($urandom), 1'($urandom));
         wait_done8(cyc);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (4) @(negedge clk);
      check("q16_drained", 32'(q16.size()), 32'd0);
      check("q8_drained", 32'(q8.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
